// File: rtl/sdram_port2_arbiter_if.sv
// Bundle for the second SDRAM port: two burst clients, the command channel
// and the beat strobe. The arbiter uses 'master', clients/controller use 'slave'.
interface sdram_port2_arbiter_if #(
    parameter int ASIZE = 23,
    parameter int LEN_W = 11
);
    logic             c0_req;
    logic [ASIZE-1:0] c0_addr;
    logic [LEN_W-1:0] c0_len;
    logic             c0_gnt;
    logic             c0_done;

    logic             c1_req;
    logic [ASIZE-1:0] c1_addr;
    logic [LEN_W-1:0] c1_len;
    logic             c1_gnt;
    logic             c1_done;

    logic             err;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [ASIZE-1:0] cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             beat;

    modport master (
        input  c0_req, c0_addr, c0_len, c1_req, c1_addr, c1_len, cmd_ready, beat,
        output c0_gnt, c0_done, c1_gnt, c1_done, err,
               cmd_valid, cmd_we, cmd_addr, cmd_len
    );

    modport slave (
        output c0_req, c0_addr, c0_len, c1_req, c1_addr, c1_len, cmd_ready, beat,
        input  c0_gnt, c0_done, c1_gnt, c1_done, err,
               cmd_valid, cmd_we, cmd_addr, cmd_len
    );
endinterface

// File: rtl/sdram_port2_arbiter.sv
// Round-robin arbiter and burst sequencer for SDRAM port 2: grants one client,
// issues a single burst command, counts beats, aborts stalled bursts.
module sdram_port2_arbiter #(
    parameter int ASIZE   = 23,
    parameter int LEN_W   = 11,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sdram_port2_arbiter_if.master  bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_XFER    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0]       state_q,      state_d;
    logic             last_owner_q, last_owner_d;
    logic [LEN_W-1:0] cnt_q,        cnt_d;
    logic [WD_W-1:0]  wd_q,         wd_d;
    logic             c0_gnt_q,     c0_gnt_d;
    logic             c1_gnt_q,     c1_gnt_d;
    logic             c0_done_q,    c0_done_d;
    logic             c1_done_q,    c1_done_d;
    logic             err_q,        err_d;
    logic             cmd_valid_q,  cmd_valid_d;
    logic             cmd_we_q,     cmd_we_d;
    logic [ASIZE-1:0] cmd_addr_q,   cmd_addr_d;
    logic [LEN_W-1:0] cmd_len_q,    cmd_len_d;

    logic             pick1_s;
    logic [LEN_W-1:0] len_s;
    logic             finish_s;
    logic             abort_s;

    // Next-state logic for the arbitration / burst sequencing FSM.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        wd_d         = wd_q;
        c0_gnt_d     = c0_gnt_q;
        c1_gnt_d     = c1_gnt_q;
        c0_done_d    = 1'b0;
        c1_done_d    = 1'b0;
        err_d        = 1'b0;
        cmd_valid_d  = cmd_valid_q;
        cmd_we_d     = cmd_we_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_len_d    = cmd_len_q;
        finish_s     = 1'b0;
        abort_s      = 1'b0;
        // Client 1 wins when it is alone, or on a tie when client 0 went last.
        pick1_s      = bus.c1_req & (~bus.c0_req | ~last_owner_q);
        len_s        = pick1_s ? bus.c1_len : bus.c0_len;

        case (state_q)
            ST_IDLE: begin
                if (bus.c0_req | bus.c1_req) begin
                    cmd_we_d   = pick1_s;
                    cmd_addr_d = pick1_s ? bus.c1_addr : bus.c0_addr;
                    cmd_len_d  = len_s;
                    c0_gnt_d   = ~pick1_s;
                    c1_gnt_d   = pick1_s;
                    cnt_d      = {LEN_W{1'b0}};
                    wd_d       = {WD_W{1'b0}};
                    // A zero-length burst skips the command; the empty count completes at once.
                    if (len_s == {LEN_W{1'b0}}) begin
                        cmd_valid_d = 1'b0;
                        state_d     = ST_XFER;
                    end else begin
                        cmd_valid_d = 1'b1;
                        state_d     = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    cnt_d       = {LEN_W{1'b0}};
                    wd_d        = wd_q + WD_W'(1);
                    state_d     = ST_XFER;
                end else if (wd_q == WD_LAST) begin
                    finish_s = 1'b1;
                    abort_s  = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_XFER: begin
                // Completion is checked before the watchdog so a final beat never aborts.
                if (cnt_q == cmd_len_q) begin
                    finish_s = 1'b1;
                end else if (bus.beat) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    wd_d  = {WD_W{1'b0}};
                end else if (wd_q == WD_LAST) begin
                    finish_s = 1'b1;
                    abort_s  = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_RELEASE: begin
                last_owner_d = cmd_we_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish_s) begin
            state_d     = ST_RELEASE;
            c0_done_d   = ~cmd_we_q;
            c1_done_d   = cmd_we_q;
            err_d       = abort_s;
            c0_gnt_d    = 1'b0;
            c1_gnt_d    = 1'b0;
            cmd_valid_d = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;
            cnt_q        <= {LEN_W{1'b0}};
            wd_q         <= {WD_W{1'b0}};
            c0_gnt_q     <= 1'b0;
            c1_gnt_q     <= 1'b0;
            c0_done_q    <= 1'b0;
            c1_done_q    <= 1'b0;
            err_q        <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= {ASIZE{1'b0}};
            cmd_len_q    <= {LEN_W{1'b0}};
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            wd_q         <= wd_d;
            c0_gnt_q     <= c0_gnt_d;
            c1_gnt_q     <= c1_gnt_d;
            c0_done_q    <= c0_done_d;
            c1_done_q    <= c1_done_d;
            err_q        <= err_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_we_q     <= cmd_we_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_len_q    <= cmd_len_d;
        end
    end

    assign bus.c0_gnt    = c0_gnt_q;
    assign bus.c1_gnt    = c1_gnt_q;
    assign bus.c0_done   = c0_done_q;
    assign bus.c1_done   = c1_done_q;
    assign bus.err       = err_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_we    = cmd_we_q;
    assign bus.cmd_addr  = cmd_addr_q;
    assign bus.cmd_len   = cmd_len_q;
endmodule
